// File: rtl/branch_predictor_pkg.sv
// Shared opcode and counter encodings for the fetch-side branch predictor.
package branch_predictor_pkg;

   localparam logic [6:0] B_TYPE      = 7'b1100011;
   localparam logic [6:0] J_TYPE      = 7'b1101111;
   localparam logic [6:0] I_TYPE_JALR = 7'b1100111;

   localparam logic [1:0] BP_CTR_SNT  = 2'b00;
   localparam logic [1:0] BP_CTR_WNT  = 2'b01;
   localparam logic [1:0] BP_CTR_WT   = 2'b10;
   localparam logic [1:0] BP_CTR_ST   = 2'b11;
   localparam logic [1:0] BP_CTR_INIT = BP_CTR_WNT;

   function automatic logic is_ctl_op(input logic [6:0] op);
      return (op == B_TYPE) || (op == J_TYPE) || (op == I_TYPE_JALR);
   endfunction

   function automatic logic is_jmp_op(input logic [6:0] op);
      return (op == J_TYPE) || (op == I_TYPE_JALR);
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter next-state logic.
module bp_sat_ctr
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       inc,
   output logic [1:0] ctr_n
);

   always_comb begin
      ctr_n = ctr;
      if (inc) begin
         if (ctr != BP_CTR_ST) ctr_n = ctr + 2'd1;
      end else begin
         if (ctr != BP_CTR_SNT) ctr_n = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters: F-stage lookup, E-stage training,
// mispredict detection and saturating performance counters.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned IDX_W = 6,
   parameter int unsigned TAG_W = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [31:0]      pcF,
   output logic             pred_takenF,
   output logic [31:0]      pred_pcF,
   input  logic             validE,
   input  logic [31:0]      instrE,
   input  logic [31:0]      pcE,
   input  logic             br_selE,
   input  logic [31:0]      targetE,
   input  logic             pred_takenE,
   input  logic [31:0]      pred_pcE,
   output logic             mispredictE,
   output logic [31:0]      redirect_pcE,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned Entries = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CntMax = '1;

   // Flop array rather than SRAM so reset can clear every entry in one cycle.
   logic [Entries-1:0] v_q;
   logic [Entries-1:0] jmp_q;
   logic [TAG_W-1:0]   tag_q [Entries];
   logic [31:0]        tgt_q [Entries];
   logic [1:0]         ctr_q [Entries];

   logic [CNT_W-1:0]   br_cnt_q, mispred_cnt_q;

   logic [IDX_W-1:0]   idx_f, idx_e;
   logic [TAG_W-1:0]   tag_f, tag_e;
   logic               hit_f, hit_e;
   logic               ctl, jmp_e, taken_e;
   logic [1:0]         ctr_n_e;
   logic               unused_instr;

   assign idx_f = pcF[IDX_W+1:2];
   assign tag_f = pcF[IDX_W+TAG_W+1:IDX_W+2];
   assign idx_e = pcE[IDX_W+1:2];
   assign tag_e = pcE[IDX_W+TAG_W+1:IDX_W+2];

   assign hit_f       = v_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_takenF = rst_ni && hit_f && (jmp_q[idx_f] || ctr_q[idx_f][1]);
   assign pred_pcF    = pred_takenF ? tgt_q[idx_f] : pcF + 32'd4;

   assign ctl     = validE && is_ctl_op(instrE[6:0]);
   assign jmp_e   = is_jmp_op(instrE[6:0]);
   assign taken_e = ctl && br_selE;
   assign hit_e   = v_q[idx_e] && (tag_q[idx_e] == tag_e);

   // Non-control instructions count as not-taken, so a stale taken prediction flushes.
   assign mispredictE  = rst_ni && validE &&
                         ((pred_takenE != taken_e) || (taken_e && (pred_pcE != targetE)));
   assign redirect_pcE = taken_e ? targetE : pcE + 32'd4;

   assign br_cnt       = br_cnt_q;
   assign mispred_cnt  = mispred_cnt_q;
   assign unused_instr = ^instrE[31:7];

   bp_sat_ctr u_sat_ctr (
      .ctr   (ctr_n_e_src()),
      .inc   (br_selE),
      .ctr_n (ctr_n_e)
   );

   function automatic logic [1:0] ctr_n_e_src();
      return ctr_q[idx_e];
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v_q           <= '0;
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
         for (int i = 0; i < Entries; i++) ctr_q[i] <= BP_CTR_INIT;
      end else begin
         if (ctl) begin
            if (hit_e) begin
               ctr_q[idx_e] <= ctr_n_e;
               if (br_selE) begin
                  tgt_q[idx_e] <= targetE;
                  jmp_q[idx_e] <= jmp_e;
               end
            end else if (br_selE) begin
               v_q[idx_e]   <= 1'b1;
               tag_q[idx_e] <= tag_e;
               tgt_q[idx_e] <= targetE;
               jmp_q[idx_e] <= jmp_e;
               ctr_q[idx_e] <= BP_CTR_WT;
            end
         end else if (validE && pred_takenE) begin
            v_q[idx_e] <= 1'b0;
         end
         if (ctl && (br_cnt_q != CntMax)) br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (mispredictE && (mispred_cnt_q != CntMax)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, random traffic against a behavioural model,
// and counter saturation on a narrow-counter instance.
module tb_branch_predictor;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] pcF, instrE, pcE, targetE, pred_pcE;
   logic        validE, br_selE, pred_takenE;
   logic        pred_takenF, mispredictE;
   logic [31:0] pred_pcF, redirect_pcE, br_cnt, mispred_cnt;
   logic        s_takenF, s_mis;
   logic [31:0] s_pcF, s_redir;
   logic [2:0]  s_br_cnt, s_mis_cnt;

   int nchk = 0;
   int nerr = 0;

   always #5 clk_i = ~clk_i;

   branch_predictor dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pcF(pcF), .pred_takenF(pred_takenF),
      .pred_pcF(pred_pcF), .validE(validE), .instrE(instrE), .pcE(pcE),
      .br_selE(br_selE), .targetE(targetE), .pred_takenE(pred_takenE),
      .pred_pcE(pred_pcE), .mispredictE(mispredictE), .redirect_pcE(redirect_pcE),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_predictor #(.CNT_W(3)) dut_s (
      .clk_i(clk_i), .rst_ni(rst_ni), .pcF(pcF), .pred_takenF(s_takenF),
      .pred_pcF(s_pcF), .validE(validE), .instrE(instrE), .pcE(pcE),
      .br_selE(br_selE), .targetE(targetE), .pred_takenE(pred_takenE),
      .pred_pcE(pred_pcE), .mispredictE(s_mis), .redirect_pcE(s_redir),
      .br_cnt(s_br_cnt), .mispred_cnt(s_mis_cnt)
   );

   localparam logic [31:0] BEQ = 32'h0000_0063;
   localparam logic [31:0] JAL = 32'h0000_006F;
   localparam logic [31:0] JALR = 32'h0000_0067;
   localparam logic [31:0] ADD = 32'h0000_0033;
   localparam logic [31:0] ADDI = 32'h0000_0013;

   typedef struct {
      logic        rst;
      logic [31:0] pcf;
      logic        vld;
      logic [31:0] instr;
      logic [31:0] pce;
      logic        br;
      logic [31:0] tgt;
      logic        pt;
      logic [31:0] ppc;
      logic        e_tk;
      logic [31:0] e_pc;
      logic        e_mis;
      logic [31:0] e_rd;
   } vec_t;

   // Behavioural model state: one record per table slot, counters as plain integers.
   bit          m_v   [64];
   bit          m_jmp [64];
   int unsigned m_tag [64];
   logic [31:0] m_tgt [64];
   int          m_ctr [64];
   longint      m_br, m_mis, m_br3, m_mis3;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_ctl(input logic [31:0] ins);
      return ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h67;
   endfunction

   function automatic int unsigned ix(input logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   function automatic int unsigned tg(input logic [31:0] pc);
      return (pc / 256) % 256;
   endfunction

   task automatic model_step();
      bit ctl, tk, mis;
      int unsigned i;
      ctl = validE && is_ctl(instrE);
      tk  = ctl && br_selE;
      mis = validE && ((pred_takenE != tk) || (tk && pred_pcE != targetE));
      i   = ix(pcE);
      if (!rst_ni) begin
         for (int k = 0; k < 64; k++) begin
            m_v[k] = 0;
            m_ctr[k] = 1;
         end
         m_br = 0; m_mis = 0; m_br3 = 0; m_mis3 = 0;
         return;
      end
      if (ctl) begin
         if (m_v[i] && m_tag[i] == tg(pcE)) begin
            m_ctr[i] = br_selE ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1)
                               : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
            if (br_selE) begin
               m_tgt[i] = targetE;
               m_jmp[i] = (instrE[6:0] != 7'h63);
            end
         end else if (br_selE) begin
            m_v[i] = 1; m_tag[i] = tg(pcE); m_tgt[i] = targetE;
            m_jmp[i] = (instrE[6:0] != 7'h63); m_ctr[i] = 2;
         end
      end else if (validE && pred_takenE) begin
         m_v[i] = 0;
      end
      if (ctl) begin
         if (m_br < 64'hFFFF_FFFF) m_br++;
         if (m_br3 < 7) m_br3++;
      end
      if (mis) begin
         if (m_mis < 64'hFFFF_FFFF) m_mis++;
         if (m_mis3 < 7) m_mis3++;
      end
   endtask

   task automatic model_check();
      int unsigned i;
      bit hit, tkf, ctl, tk, mis;
      i   = ix(pcF);
      hit = m_v[i] && m_tag[i] == tg(pcF);
      tkf = rst_ni && hit && (m_jmp[i] || m_ctr[i] >= 2);
      ctl = validE && is_ctl(instrE);
      tk  = ctl && br_selE;
      mis = rst_ni && validE && ((pred_takenE != tk) || (tk && pred_pcE != targetE));
      chk("m_takenF", {31'b0, pred_takenF}, {31'b0, tkf});
      chk("m_pcF", pred_pcF, tkf ? m_tgt[i] : pcF + 32'd4);
      chk("m_mis", {31'b0, mispredictE}, {31'b0, mis});
      if (mis) chk("m_redir", redirect_pcE, tk ? targetE : pcE + 32'd4);
      chk("m_br_cnt", br_cnt, m_br[31:0]);
      chk("m_mis_cnt", mispred_cnt, m_mis[31:0]);
      chk("m_br_cnt3", {29'b0, s_br_cnt}, m_br3[31:0]);
      chk("m_mis_cnt3", {29'b0, s_mis_cnt}, m_mis3[31:0]);
   endtask

   task automatic run_cycle(input vec_t t, input bit use_exp);
      rst_ni = t.rst; pcF = t.pcf; validE = t.vld; instrE = t.instr; pcE = t.pce;
      br_selE = t.br; targetE = t.tgt; pred_takenE = t.pt; pred_pcE = t.ppc;
      #3;
      model_check();
      if (use_exp) begin
         chk("v_takenF", {31'b0, pred_takenF}, {31'b0, t.e_tk});
         chk("v_pcF", pred_pcF, t.e_pc);
         chk("v_mis", {31'b0, mispredictE}, {31'b0, t.e_mis});
         if (t.e_mis) chk("v_redir", redirect_pcE, t.e_rd);
      end
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   function automatic vec_t mk(input logic rst, input logic [31:0] pcf, input logic vld,
                               input logic [31:0] ins, input logic [31:0] pce,
                               input logic br, input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ppc, input logic e_tk,
                               input logic [31:0] e_pc, input logic e_mis,
                               input logic [31:0] e_rd);
      vec_t v;
      v.rst = rst; v.pcf = pcf; v.vld = vld; v.instr = ins; v.pce = pce; v.br = br;
      v.tgt = tgt; v.pt = pt; v.ppc = ppc; v.e_tk = e_tk; v.e_pc = e_pc;
      v.e_mis = e_mis; v.e_rd = e_rd;
      return v;
   endfunction

   function automatic vec_t idle(input logic [31:0] pcf, input logic e_tk,
                                 input logic [31:0] e_pc);
      return mk(1, pcf, 0, ADD, 0, 0, 0, 0, 0, e_tk, e_pc, 0, 0);
   endfunction

   vec_t tbl[$];
   vec_t r;

   initial begin
      rst_ni = 0; pcF = 0; validE = 0; instrE = 0; pcE = 0; br_selE = 0;
      targetE = 0; pred_takenE = 0; pred_pcE = 0;
      @(posedge clk_i);
      model_step();
      #1;

      tbl.push_back(mk(0, 32'h100, 0, ADD, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
      tbl.push_back(idle(32'hFFFF_FFFC, 0, 32'h0));
      tbl.push_back(idle(32'h100, 0, 32'h104));
      tbl.push_back(mk(1, 32'h100, 1, BEQ, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80));
      tbl.push_back(mk(1, 32'h100, 1, BEQ, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104));
      tbl.push_back(mk(1, 32'h100, 1, BEQ, 32'h100, 0, 32'h80, 1, 32'h80, 0, 32'h104, 1, 32'h104));
      tbl.push_back(idle(32'h100, 0, 32'h104));
      tbl.push_back(mk(1, 32'h200, 1, JAL, 32'h200, 1, 32'h400, 0, 32'h204, 0, 32'h204, 1, 32'h400));
      for (int k = 0; k < 3; k++) tbl.push_back(idle(32'h200, 1, 32'h400));
      tbl.push_back(mk(1, 32'h200, 1, JALR, 32'h200, 1, 32'h500, 1, 32'h400, 1, 32'h400, 1, 32'h500));
      tbl.push_back(idle(32'h200, 1, 32'h500));
      // Aliased non-control hit: same-cycle F lookup still sees the old entry.
      tbl.push_back(mk(1, 32'h200, 1, ADD, 32'h200, 0, 0, 1, 32'h500, 1, 32'h500, 1, 32'h204));
      tbl.push_back(idle(32'h200, 0, 32'h204));
      tbl.push_back(mk(1, 32'h40, 1, JAL, 32'h40, 1, 32'h1000, 0, 32'h44, 0, 32'h44, 1, 32'h1000));
      tbl.push_back(idle(32'h40, 1, 32'h1000));
      // Reset during a taken-branch update at an aliasing index.
      tbl.push_back(mk(0, 32'h40, 1, BEQ, 32'h140, 1, 32'h80, 0, 32'h144, 0, 32'h44, 0, 0));
      tbl.push_back(idle(32'h40, 0, 32'h44));
      tbl.push_back(idle(32'h140, 0, 32'h144));

      foreach (tbl[k]) run_cycle(tbl[k], 1'b1);

      for (int n = 0; n < 600; n++) begin
         logic [31:0] ops [5];
         ops[0] = BEQ; ops[1] = JAL; ops[2] = JALR; ops[3] = ADD; ops[4] = ADDI;
         r.rst   = ($urandom_range(0, 59) != 0);
         r.pcf   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         r.pce   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         r.vld   = ($urandom_range(0, 3) != 0);
         r.instr = ops[$urandom_range(0, 4)] | ($urandom() & 32'hFFFF_FF80);
         r.br    = $urandom_range(0, 1);
         r.tgt   = $urandom_range(0, 3) << 6;
         r.pt    = $urandom_range(0, 1);
         r.ppc   = $urandom_range(0, 1) ? r.tgt : r.pce + 32'd4;
         run_cycle(r, 1'b0);
      end

      run_cycle(mk(0, 32'h100, 0, ADD, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0), 1'b1);
      for (int k = 0; k < 9; k++)
         run_cycle(mk(1, 32'h100, 1, ADD, 32'h300, 0, 0, 1, 32'h80, 0, 32'h104, 1, 32'h304), 1'b1);
      chk("sat_mis_cnt3", {29'b0, s_mis_cnt}, 32'd7);
      chk("mis_cnt32", mispred_cnt, 32'd9);
      chk("br_cnt_nonctl", br_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
